// File: rtl/pgr_apb_mst_32bit_if.sv
// rtl/pgr_apb_mst_32bit_if.sv - APB3/APB4 bus bundle between the command master and its slave
interface pgr_apb_mst_32bit_if #(
  parameter int ADDR_W = 16
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/pgr_apb_mst_32bit.sv
// rtl/pgr_apb_mst_32bit.sv - turns one parsed UART command into one APB transfer, returns read data as 4 bytes LSB first
module pgr_apb_mst_32bit #(
  parameter int          ADDR_W      = 16,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] TO_RDATA    = 32'hFFFF_FFFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_en,
  input  logic                     we,
  input  logic [15:0]              addr,
  input  logic [31:0]              data,
  input  logic [3:0]               strb,
  output logic                     cmd_done,
  output logic                     cmd_err,
  pgr_apb_mst_32bit_if.master      apb,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready
);

  localparam int                 CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]   TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_TX,
    S_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              err;
  logic [23:0]       rdata_hi;
  logic [1:0]        byte_idx;

  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [31:0]       pwdata_q;
  logic [3:0]        pstrb_q;

  logic              xfer_end;
  logic              end_err;
  logic [31:0]       end_rdata;

  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.pstrb   = pstrb_q;

  // An ACCESS cycle ends either on pready or on the last allowed wait cycle.
  always_comb begin
    xfer_end  = apb.pready || (cnt == TO_LAST);
    end_err   = apb.pready ? apb.pslverr : 1'b1;
    end_rdata = apb.pready ? apb.prdata : TO_RDATA;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      err       <= 1'b0;
      rdata_hi  <= '0;
      byte_idx  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      cmd_done  <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_en) begin
            pwrite_q <= we;
            paddr_q  <= ADDR_W'(addr);
            pwdata_q <= data;
            pstrb_q  <= we ? strb : 4'h0;
            psel_q   <= 1'b1;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          cnt       <= '0;
          state     <= S_ACCESS;
        end
        S_ACCESS: begin
          if (xfer_end) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            err       <= end_err;
            if (pwrite_q) begin
              cmd_done <= 1'b1;
              cmd_err  <= end_err;
              state    <= S_DONE;
            end else begin
              tx_data  <= end_rdata[7:0];
              rdata_hi <= end_rdata[31:8];
              byte_idx <= '0;
              tx_valid <= 1'b1;
              state    <= S_TX;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_TX: begin
          // tx_valid is held high for the whole of TX, so tx_ready alone marks a handshake.
          if (tx_ready) begin
            if (byte_idx == 2'd3) begin
              tx_valid <= 1'b0;
              cmd_done <= 1'b1;
              cmd_err  <= err;
              state    <= S_DONE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              tx_data  <= rdata_hi[7:0];
              rdata_hi <= {8'h00, rdata_hi[23:8]};
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pgr_apb_mst_32bit.sv
// tb/tb_pgr_apb_mst_32bit.sv - scoreboard bench for the UART-command APB master
module tb_pgr_apb_mst_32bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_en = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] data = '0;
  logic [3:0]  strb = '0;
  logic        cmd_done;
  logic        cmd_err;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;

  pgr_apb_mst_32bit_if #(.ADDR_W(16)) apb_if ();

  pgr_apb_mst_32bit #(
    .ADDR_W      (16),
    .TIMEOUT_CYC (8),
    .TO_RDATA    (32'hFFFF_FFFF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_en   (cmd_en),
    .we       (we),
    .addr     (addr),
    .data     (data),
    .strb     (strb),
    .cmd_done (cmd_done),
    .cmd_err  (cmd_err),
    .apb      (apb_if),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         hs_cnt = 0;
  int         txv_seen = 0;
  int         last_hs_cyc = -1;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Byte scoreboard: every handshake pops one expected byte; stalled bytes must hold.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (tx_valid) begin
      txv_seen = txv_seen + 1;
      if (prev_stall) begin
        n_cmp = n_cmp + 1;
        if (tx_data !== prev_data) begin
          n_bad = n_bad + 1;
          $display("FAIL tx_stable: got %h want %h", tx_data, prev_data);
        end
      end
      if (tx_ready) begin
        hs_cnt = hs_cnt + 1;
        last_hs_cyc = cyc;
        n_cmp = n_cmp + 1;
        if (exp_q.size() == 0) begin
          n_bad = n_bad + 1;
          $display("FAIL tx_byte: got %h want none", tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (tx_data !== exp_b) begin
            n_bad = n_bad + 1;
            $display("FAIL tx_byte: got %h want %h", tx_data, exp_b);
          end
        end
      end
      prev_stall = !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    we     = w;
    addr   = a;
    data   = d;
    strb   = s;
    cmd_en = 1'b1;
    tick();
    cmd_en = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at_cyc, output logic err_v);
    at_cyc = -1;
    err_v  = 1'bx;
    for (int i = 0; i < budget; i++) begin
      if (cmd_done) begin
        at_cyc = cyc;
        err_v  = cmd_err;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp = n_cmp + 1;
    if ({apb_if.psel, apb_if.penable, apb_if.pwrite, apb_if.pstrb, tx_valid, cmd_done, cmd_err} !== 10'h0) begin
      n_bad = n_bad + 1;
      $display("FAIL reset_ctrl: got %b want 0", {apb_if.psel, apb_if.penable, apb_if.pwrite, apb_if.pstrb, tx_valid, cmd_done, cmd_err});
    end
    n_cmp = n_cmp + 1;
    if (apb_if.paddr !== 16'h0) begin
      n_bad = n_bad + 1;
      $display("FAIL reset_paddr: got %h want 0", apb_if.paddr);
    end
    n_cmp = n_cmp + 1;
    if (apb_if.pwdata !== 32'h0) begin
      n_bad = n_bad + 1;
      $display("FAIL reset_pwdata: got %h want 0", apb_if.pwdata);
    end
    n_cmp = n_cmp + 1;
    if (tx_data !== 8'h0) begin
      n_bad = n_bad + 1;
      $display("FAIL reset_tx_data: got %h want 0", tx_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    int c0, txv0;
    apb_if.pready  = 1'b1;
    apb_if.pslverr = 1'b0;
    txv0 = txv_seen;
    c0   = cyc;
    issue(1'b1, 16'h1234, 32'hA5A5_5A5A, 4'hF);
    n_cmp = n_cmp + 1;
    if ({apb_if.psel, apb_if.penable, apb_if.pwrite} !== 3'b101) begin
      n_bad = n_bad + 1;
      $display("FAIL wr_setup: got %b want 101", {apb_if.psel, apb_if.penable, apb_if.pwrite});
    end
    n_cmp = n_cmp + 1;
    if ({apb_if.paddr, apb_if.pwdata, apb_if.pstrb} !== {16'h1234, 32'hA5A5_5A5A, 4'hF}) begin
      n_bad = n_bad + 1;
      $display("FAIL wr_fields: got %h/%h/%h want 1234/a5a55a5a/f", apb_if.paddr, apb_if.pwdata, apb_if.pstrb);
    end
    tick();
    n_cmp = n_cmp + 1;
    if ({apb_if.psel, apb_if.penable, cmd_done} !== 3'b110) begin
      n_bad = n_bad + 1;
      $display("FAIL wr_access: got %b want 110", {apb_if.psel, apb_if.penable, cmd_done});
    end
    tick();
    n_cmp = n_cmp + 1;
    if ({cmd_done, cmd_err, apb_if.psel, apb_if.penable} !== 4'b1000 || cyc != c0 + 3) begin
      n_bad = n_bad + 1;
      $display("FAIL wr_done: got %b at +%0d want 1000 at +3", {cmd_done, cmd_err, apb_if.psel, apb_if.penable}, cyc - c0);
    end
    tick();
    n_cmp = n_cmp + 1;
    if (cmd_done !== 1'b0 || txv_seen != txv0) begin
      n_bad = n_bad + 1;
      $display("FAIL wr_after: got done=%b tx=%0d want 0 0", cmd_done, txv_seen - txv0);
    end
  endtask

  task automatic test_read_wait();
    int   hs0, waits, acc, done_c;
    logic e;
    hs0 = hs_cnt;
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h11);
    apb_if.pready = 1'b0;
    apb_if.prdata = 32'h1122_3344;
    tx_ready = 1'b1;
    issue(1'b0, 16'h0010, 32'hDEAD_0000, 4'hF);
    n_cmp = n_cmp + 1;
    if ({apb_if.pwrite, apb_if.pstrb, apb_if.paddr} !== {1'b0, 4'h0, 16'h0010}) begin
      n_bad = n_bad + 1;
      $display("FAIL rd_setup: got %b/%h/%h want 0/0/0010", apb_if.pwrite, apb_if.pstrb, apb_if.paddr);
    end
    waits  = 0;
    acc    = 0;
    done_c = -1;
    e      = 1'bx;
    for (int i = 0; i < 40; i++) begin
      if (cmd_done) begin
        done_c = cyc;
        e = cmd_err;
        break;
      end
      if (apb_if.psel && apb_if.penable) begin
        acc++;
        if (waits == 3) apb_if.pready = 1'b1;
        else waits++;
      end
      tick();
    end
    apb_if.pready = 1'b1;
    n_cmp = n_cmp + 1;
    if (acc != 4) begin
      n_bad = n_bad + 1;
      $display("FAIL rd_access_cycles: got %0d want 4", acc);
    end
    n_cmp = n_cmp + 1;
    if (done_c < 0 || done_c != last_hs_cyc + 1 || e !== 1'b0) begin
      n_bad = n_bad + 1;
      $display("FAIL rd_done: got cyc %0d err %b want cyc %0d err 0", done_c, e, last_hs_cyc + 1);
    end
    n_cmp = n_cmp + 1;
    if (hs_cnt - hs0 != 4 || exp_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL rd_bytes: got %0d handshakes %0d left want 4 0", hs_cnt - hs0, exp_q.size());
    end
    tick();
  endtask

  task automatic test_timeout();
    int   hs0, acc, done_c;
    logic e;
    hs0 = hs_cnt;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hFF);
    apb_if.pready = 1'b0;
    apb_if.prdata = 32'h0BAD_0BAD;
    tx_ready = 1'b1;
    issue(1'b0, 16'h0020, 32'h0, 4'h0);
    acc    = 0;
    done_c = -1;
    e      = 1'bx;
    for (int i = 0; i < 60; i++) begin
      if (cmd_done) begin
        done_c = cyc;
        e = cmd_err;
        break;
      end
      if (apb_if.psel && apb_if.penable) acc++;
      tick();
    end
    apb_if.pready = 1'b1;
    n_cmp = n_cmp + 1;
    if (acc != 8) begin
      n_bad = n_bad + 1;
      $display("FAIL to_access_cycles: got %0d want 8", acc);
    end
    n_cmp = n_cmp + 1;
    if (done_c < 0 || e !== 1'b1) begin
      n_bad = n_bad + 1;
      $display("FAIL to_done: got cyc %0d err %b want done with err 1", done_c, e);
    end
    n_cmp = n_cmp + 1;
    if (hs_cnt - hs0 != 4 || exp_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL to_bytes: got %0d handshakes %0d left want 4 0", hs_cnt - hs0, exp_q.size());
    end
    tick();
  endtask

  task automatic test_write_err();
    int   c0, txv0, done_c;
    logic e;
    apb_if.pready  = 1'b1;
    apb_if.pslverr = 1'b1;
    txv0 = txv_seen;
    c0   = cyc;
    issue(1'b1, 16'h0044, 32'h0000_00FF, 4'h1);
    wait_done(10, done_c, e);
    apb_if.pslverr = 1'b0;
    n_cmp = n_cmp + 1;
    if (done_c != c0 + 3 || e !== 1'b1) begin
      n_bad = n_bad + 1;
      $display("FAIL werr_done: got +%0d err %b want +3 err 1", done_c - c0, e);
    end
    tick();
    n_cmp = n_cmp + 1;
    if (txv_seen != txv0) begin
      n_bad = n_bad + 1;
      $display("FAIL werr_no_tx: got %0d tx_valid cycles want 0", txv_seen - txv0);
    end
  endtask

  task automatic test_tx_stall();
    int   hs0, done_c;
    logic e;
    hs0 = hs_cnt;
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'hBE);
    exp_q.push_back(8'hAD);
    exp_q.push_back(8'hDE);
    apb_if.pready = 1'b1;
    apb_if.prdata = 32'hDEAD_BEEF;
    tx_ready = 1'b1;
    issue(1'b0, 16'h0030, 32'h0, 4'h0);
    done_c = -1;
    e      = 1'bx;
    for (int i = 0; i < 40; i++) begin
      if (cmd_done) begin
        done_c = cyc;
        e = cmd_err;
        break;
      end
      tx_ready = ~tx_ready;
      tick();
    end
    tx_ready = 1'b1;
    n_cmp = n_cmp + 1;
    if (done_c < 0 || e !== 1'b0 || hs_cnt - hs0 != 4 || exp_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL stall_read: got done %0d err %b hs %0d left %0d want done err 0 hs 4 left 0", done_c, e, hs_cnt - hs0, exp_q.size());
    end
    tick();
  endtask

  task automatic test_cmd_during_access();
    int   done_c;
    logic e;
    bit   stray;
    apb_if.pready = 1'b0;
    issue(1'b1, 16'h0100, 32'h1111_2222, 4'h3);
    for (int i = 0; i < 5 && !(apb_if.psel && apb_if.penable); i++) tick();
    we     = 1'b0;
    addr   = 16'h0200;
    cmd_en = 1'b1;
    tick();
    cmd_en = 1'b0;
    n_cmp = n_cmp + 1;
    if ({apb_if.psel, apb_if.penable, apb_if.pwrite, apb_if.paddr} !== {3'b111, 16'h0100}) begin
      n_bad = n_bad + 1;
      $display("FAIL busy_ignore: got %b/%h want 111/0100", {apb_if.psel, apb_if.penable, apb_if.pwrite}, apb_if.paddr);
    end
    apb_if.pready = 1'b1;
    wait_done(10, done_c, e);
    stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (apb_if.psel) stray = 1'b1;
    end
    n_cmp = n_cmp + 1;
    if (done_c < 0 || e !== 1'b0 || stray) begin
      n_bad = n_bad + 1;
      $display("FAIL busy_after: got done %0d err %b stray %b want done err 0 stray 0", done_c, e, stray);
    end
  endtask

  task automatic test_back_to_back();
    int   done_c;
    logic e;
    apb_if.pready = 1'b1;
    issue(1'b1, 16'h0300, 32'h3333_3333, 4'hF);
    wait_done(10, done_c, e);
    we     = 1'b1;
    addr   = 16'h0400;
    data   = 32'h4444_4444;
    strb   = 4'hC;
    cmd_en = 1'b1;
    tick();
    n_cmp = n_cmp + 1;
    if (apb_if.psel !== 1'b0) begin
      n_bad = n_bad + 1;
      $display("FAIL b2b_done_ignore: got psel %b want 0", apb_if.psel);
    end
    addr = 16'h0500;
    tick();
    cmd_en = 1'b0;
    n_cmp = n_cmp + 1;
    if ({apb_if.psel, apb_if.penable, apb_if.paddr, apb_if.pstrb} !== {2'b10, 16'h0500, 4'hC}) begin
      n_bad = n_bad + 1;
      $display("FAIL b2b_accept: got %b/%h/%h want 10/0500/c", {apb_if.psel, apb_if.penable}, apb_if.paddr, apb_if.pstrb);
    end
    wait_done(10, done_c, e);
    n_cmp = n_cmp + 1;
    if (done_c < 0 || e !== 1'b0) begin
      n_bad = n_bad + 1;
      $display("FAIL b2b_done: got cyc %0d err %b want done err 0", done_c, e);
    end
    tick();
  endtask

  task automatic test_reset_in_tx();
    bit saw_done;
    bit in_tx;
    apb_if.pready = 1'b1;
    apb_if.prdata = 32'h5566_7788;
    tx_ready = 1'b0;
    issue(1'b0, 16'h0600, 32'h0, 4'h0);
    in_tx = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (tx_valid) begin
        in_tx = 1'b1;
        break;
      end
      tick();
    end
    n_cmp = n_cmp + 1;
    if (!in_tx) begin
      n_bad = n_bad + 1;
      $display("FAIL rst_reach_tx: got no tx_valid want tx_valid");
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    saw_done = cmd_done;
    n_cmp = n_cmp + 1;
    if ({tx_valid, apb_if.psel, apb_if.penable} !== 3'b000) begin
      n_bad = n_bad + 1;
      $display("FAIL rst_tx_drop: got %b want 000", {tx_valid, apb_if.psel, apb_if.penable});
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cmd_done || tx_valid) saw_done = 1'b1;
    end
    n_cmp = n_cmp + 1;
    if (saw_done) begin
      n_bad = n_bad + 1;
      $display("FAIL rst_no_done: got cmd_done/tx_valid after reset want none");
    end
    tx_ready = 1'b1;
  endtask

  initial begin
    apb_if.prdata  = 32'h0;
    apb_if.pready  = 1'b1;
    apb_if.pslverr = 1'b0;
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_write_err();
    test_tx_stall();
    test_cmd_during_access();
    test_back_to_back();
    test_reset_in_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
